ps2_device_tx: RTL and testbench

Device-side PS/2 transmitter. It serialises queued scan-code bytes into 11-bit device-to-host frames on an open-collector PS2_CLK/PS2_DATA pair, acting as a keyboard emulator. It is the opposite end of the PS/2 host receiver in TOP. Uses: synthesizable loopback keyboard and reusable keystroke stimulus for system benches. Includes a small byte FIFO so make/break sequences (e.g. F0 xx) can be queued in one burst.

---
 rtl/ps2_device_tx.sv | 163 ++++++++++++++++
 tb/tb_ps2_device_tx.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device_tx.sv
// Device-side PS/2 transmitter: queues scan-code bytes in a small FIFO and clocks
// them out as 11-bit device-to-host frames on an open-collector clock/data pair.
module ps2_device_tx #(
    parameter int unsigned HALF_PERIOD  = 4000,
    parameter int unsigned GAP_CYCLES   = 5000,
    parameter int unsigned INHIBIT_HOLD = 5000,
    parameter int unsigned FIFO_AW      = 2
) (
    input  logic       CLK100MHZ,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       PS2_CLK_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       BUSY,
    output logic       ABORTED
);
    localparam int unsigned DEPTH   = 1 << FIFO_AW;
    localparam int unsigned CNT_MAX = (HALF_PERIOD > GAP_CYCLES) ? HALF_PERIOD : GAP_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(INHIBIT_HOLD + 1);

    typedef enum logic [1:0] {S_IDLE, S_BIT_HIGH, S_BIT_LOW, S_GAP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         idx_q, idx_d;
    logic [IW-1:0]      inh_q, inh_d;
    logic               sync1_q, clk_s_q;
    logic               clk_oe_q, clk_oe_d;
    logic               data_oe_q, data_oe_d;
    logic               aborted_q, abort;
    logic               hold_ok;
    logic [7:0]         mem_q [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]   count_q, count_d;
    logic               push, pop;
    logic [7:0]         head;
    logic [10:0]        frame;

    // Bus clock synchroniser and "released long enough" counter.
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            sync1_q <= 1'b0;
            clk_s_q <= 1'b0;
            inh_q   <= '0;
        end else begin
            sync1_q <= PS2_CLK_IN;
            clk_s_q <= sync1_q;
            inh_q   <= inh_d;
        end
    end

    always_comb begin
        inh_d = '0;
        if (clk_s_q)
            inh_d = (inh_q == IW'(INHIBIT_HOLD)) ? inh_q : inh_q + 1'b1;
    end

    // Start decision sees the count as it saturates, so the frame begins on that edge.
    assign hold_ok = (inh_d == IW'(INHIBIT_HOLD));

    assign TX_READY = (count_q != (FIFO_AW + 1)'(DEPTH));
    assign push     = TX_VALID && TX_READY;
    assign head     = mem_q[rd_ptr_q];
    assign frame    = {1'b1, ~^head, head, 1'b0};

    always_ff @(posedge CLK100MHZ) begin
        if (push)
            mem_q[wr_ptr_q] <= TX_DATA;
    end

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        pop     = 1'b0;
        abort   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (count_q != '0 && hold_ok) begin
                    state_d = S_BIT_HIGH;
                    idx_d   = '0;
                end
            end
            S_BIT_HIGH: begin
                // Ignore the first cycles: clk_s still reflects our own low phase.
                if (!clk_s_q && cnt_q >= CW'(3)) begin
                    abort   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CW'(HALF_PERIOD - 1)) begin
                    state_d = S_BIT_LOW;
                    cnt_d   = '0;
                end
            end
            S_BIT_LOW: begin
                if (cnt_q == CW'(HALF_PERIOD - 1)) begin
                    cnt_d = '0;
                    if (idx_q == 4'd10) begin
                        pop     = 1'b1;
                        state_d = S_GAP;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_BIT_HIGH;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
        clk_oe_d  = (state_d == S_BIT_LOW);
        data_oe_d = (state_d == S_BIT_HIGH || state_d == S_BIT_LOW) && !frame[idx_d];
    end

    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            aborted_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            aborted_q <= abort;
            count_q   <= count_d;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    assign PS2_CLK_OE  = clk_oe_q;
    assign PS2_DATA_OE = data_oe_q;
    assign ABORTED     = aborted_q;
    assign BUSY        = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: a frame-timeline model predicts every output each cycle,
// a bus monitor decodes frames, and directed plus random traffic exercises both.
module tb_ps2_device_tx;
    localparam int HP    = 4;
    localparam int GAPC  = 8;
    localparam int HOLD  = 6;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, clk_oe, data_oe, busy, aborted;
    logic       host_low = 1'b0;
    logic       ps2_clk_in;

    always #5 clk = ~clk;

    // Wired-AND bus: released clock reads high unless we or the host pull it low.
    assign ps2_clk_in = ~(clk_oe | host_low);

    ps2_device_tx #(
        .HALF_PERIOD (HP),
        .GAP_CYCLES  (GAPC),
        .INHIBIT_HOLD(HOLD),
        .FIFO_AW     (2)
    ) dut (
        .CLK100MHZ  (clk),
        .RESET      (rst),
        .TX_DATA    (tx_data),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .PS2_CLK_IN (ps2_clk_in),
        .PS2_CLK_OE (clk_oe),
        .PS2_DATA_OE(data_oe),
        .BUSY       (busy),
        .ABORTED    (aborted)
    );

    int tests = 0, fails = 0, cyc = 0, nprint = 0;
    bit chk_en = 0;

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = ($countones(b) % 2 == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Model: mt = cycle offset inside the current frame (-1 when none).
    logic [7:0]  mq[$];
    logic [10:0] model_sent[$];
    int  mt = -1, mgap = 0, run = 0;
    bit  d1 = 0, d2 = 0, m_cs, m_rdy, m_ab;
    logic [10:0] m_fr;
    bit  exp_clk = 0, exp_data = 0, exp_ab = 0, exp_busy = 0, exp_ready = 1;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            mq.delete();
            mt = -1; mgap = 0; run = 0; d1 = 0; d2 = 0;
            exp_clk = 0; exp_data = 0; exp_ab = 0; exp_busy = 0; exp_ready = 1;
        end else begin
            m_cs = d2; d2 = d1; d1 = ps2_clk_in;
            run = m_cs ? ((run < HOLD) ? run + 1 : HOLD) : 0;
            m_rdy = (mq.size() < DEPTH);
            m_ab = 0;
            if (mt >= 0) begin
                if ((mt % (2 * HP)) >= 3 && (mt % (2 * HP)) < HP && !m_cs) begin
                    m_ab = 1; mt = -1;
                end else if (mt == 22 * HP - 1) begin
                    model_sent.push_back(frame_of(mq.pop_front()));
                    mt = -1; mgap = GAPC;
                end else begin
                    mt++;
                end
            end else if (mgap > 0) begin
                mgap--;
            end else if (mq.size() > 0 && run >= HOLD) begin
                mt = 0;
            end
            if (tx_valid && m_rdy) mq.push_back(tx_data);
            exp_clk = (mt >= 0) && ((mt % (2 * HP)) >= HP);
            if (mt >= 0) begin
                m_fr = frame_of(mq[0]);
                exp_data = !m_fr[mt / (2 * HP)];
            end else begin
                exp_data = 0;
            end
            exp_ab = m_ab;
            exp_busy = (mt >= 0) || (mgap > 0) || (mq.size() > 0);
            exp_ready = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            tests++;
            if ({clk_oe, data_oe, aborted, busy, tx_ready} !==
                {exp_clk, exp_data, exp_ab, exp_busy, exp_ready}) begin
                fails++;
                if (nprint < 20) begin
                    nprint++;
                    $display("FAIL cycle_model @%0d: got clk_oe/data_oe/aborted/busy/ready=%b%b%b%b%b, expected %b%b%b%b%b",
                             cyc, clk_oe, data_oe, aborted, busy, tx_ready,
                             exp_clk, exp_data, exp_ab, exp_busy, exp_ready);
                end
            end
        end
    end

    // Bus monitor: samples data on each falling bus clock, as a host would.
    logic [10:0] dec[$];
    logic [10:0] bits;
    int  nb = 0, st = 0, last_len = 0, last_end = -1, min_gap = 1000, ab_cnt = 0;
    bit  in_frame = 0, p_clk = 0, p_data = 0;

    always @(negedge clk) begin
        if (rst) begin
            nb = 0; in_frame = 0;
        end else begin
            if (aborted) begin
                ab_cnt++; nb = 0; in_frame = 0;
            end
            if (!in_frame && !p_clk && !p_data && data_oe && !clk_oe) begin
                in_frame = 1; st = cyc; nb = 0;
                if (last_end >= 0 && st - last_end < min_gap) min_gap = st - last_end;
            end
            if (in_frame && clk_oe && !p_clk && nb < 11) begin
                bits[nb] = ~data_oe; nb++;
            end
            if (in_frame && nb == 11 && !clk_oe && !data_oe) begin
                dec.push_back(bits);
                last_len = cyc - st; last_end = cyc; in_frame = 0; nb = 0;
            end
        end
        p_clk = clk_oe; p_data = data_oe;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        tx_data = b; tx_valid = 1; step(); tx_valid = 0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin step(); n++; end
        check("idle_timeout", int'(busy), 0);
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (data_oe !== 1'b1 && n < budget) begin step(); n++; end
        check("start_timeout", int'(data_oe), 1);
    endtask

    task automatic wait_frames(input int k, input int budget);
        int n = 0;
        while (dec.size() < k && n < budget) begin step(); n++; end
        check("frames_timeout", int'(dec.size() >= k), 1);
    endtask

    initial begin
        int lat, hl_left;
        repeat (3) step();
        check("reset_clk_oe", int'(clk_oe), 0);
        check("reset_data_oe", int'(data_oe), 0);
        check("reset_aborted", int'(aborted), 0);
        rst = 0; #1;
        check("reset_ready", int'(tx_ready), 1);
        check("reset_busy", int'(busy), 0);
        chk_en = 1;
        repeat (20) step();

        // 0x1C: one frame, 88 cycles, BUSY through the gap
        push(8'h1C);
        wait_frames(1, 400);
        check("f1c_bits", int'(dec[0]), 'h438);
        check("f1c_len", last_len, 88);
        repeat (3) step();
        check("gap_busy", int'(busy), 1);
        repeat (7) step();
        check("after_gap_busy", int'(busy), 0);

        // burst of four, fifth ignored
        wait_idle(400);
        min_gap = 1000;
        push(8'h4D); push(8'hF0); push(8'h4D);
        tx_data = 8'h5A; tx_valid = 1; step();
        check("full_ready", int'(tx_ready), 0);
        tx_data = 8'h29; step(); tx_valid = 0;
        wait_frames(5, 1500);
        check("burst_f0", int'(dec[1]), 'h69A);
        check("burst_f1", int'(dec[2]), 'h7E0);
        check("burst_f2", int'(dec[3]), 'h69A);
        check("burst_f3", int'(dec[4]), 'h6B4);
        for (int i = 1; i <= 4; i++) check("burst_parity", int'(dec[i][9]), 1);
        check("burst_min_gap", int'(min_gap >= 8), 1);

        // held inhibit, then exact start latency (2 sync + 6 hold edges)
        wait_idle(400);
        host_low = 1;
        repeat (3) step();
        push(8'h29);
        repeat (30) step();
        check("inhibit_no_oe", int'(clk_oe | data_oe), 0);
        host_low = 0;
        lat = 0;
        while (!(clk_oe | data_oe) && lat < 50) begin step(); lat++; end
        check("start_latency", lat, 8);
        wait_frames(6, 400);
        check("f29_bits", int'(dec[5]), 'h452);

        // inhibit during D4 high phase aborts and resends
        wait_idle(400);
        push(8'h43);
        wait_start(100);
        repeat (40) step();
        host_low = 1;
        repeat (20) step();
        host_low = 0;
        wait_frames(7, 600);
        check("abort_count", ab_cnt, 1);
        check("resend_43", int'(dec[6]), 'h486);

        // inhibit during stop-bit low phase: committed, no abort
        wait_idle(400);
        push(8'h1C);
        wait_start(100);
        repeat (84) step();
        host_low = 1;
        repeat (10) step();
        host_low = 0;
        wait_frames(8, 400);
        check("stop_no_abort", ab_cnt, 1);
        check("stop_frame", int'(dec[7]), 'h438);

        // reset mid-frame with bytes queued
        wait_idle(400);
        push(8'h11); push(8'h22); push(8'h33);
        wait_start(100);
        repeat (20) step();
        rst = 1; #1;
        check("midreset_clk_oe", int'(clk_oe), 0);
        check("midreset_data_oe", int'(data_oe), 0);
        step(); step();
        rst = 0; #1;
        check("midreset_busy", int'(busy), 0);
        check("midreset_ready", int'(tx_ready), 1);
        repeat (200) step();
        check("midreset_no_frames", dec.size(), 8);

        // random traffic with random host inhibit pulses
        hl_left = 0;
        for (int i = 0; i < 4000; i++) begin
            tx_valid = ($urandom_range(0, 99) < 4);
            tx_data = 8'($urandom);
            if (hl_left > 0) begin
                hl_left--;
                if (hl_left == 0) host_low = 0;
            end else if ($urandom_range(0, 999) < 4) begin
                host_low = 1;
                hl_left = $urandom_range(1, 40);
            end
            step();
        end
        tx_valid = 0; host_low = 0;
        wait_idle(3000);

        check("frame_count", dec.size(), model_sent.size());
        for (int i = 0; i < dec.size() && i < model_sent.size(); i++)
            check("frame_content", int'(dec[i]), int'(model_sent[i]));

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
